// File: rtl/cl_cfg_write_sched.sv
// Configuration write scheduler: merges buffered Camera Link host writes and
// init-sequencer writes onto one downstream port, round-robin on ties, with a
// programmable idle gap after every completed write.
module cl_cfg_write_sched #(
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        clk_fix,
  input  logic        rst_fix,
  input  logic        rb1_wen,
  input  logic        rb2_wen,
  input  logic        rb3_wen,
  input  logic        rb4_wen,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  reg_data,
  input  logic        init_req,
  input  logic [1:0]  init_rb,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_data,
  output logic        init_ack,
  output logic        wr_valid,
  output logic [1:0]  wr_rb,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ready,
  input  logic        ovf_clr,
  output logic        host_ovf,
  output logic        busy,
  output logic [15:0] wr_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;
  localparam int unsigned ENT_W = 18;
  localparam int unsigned GAP_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_init_q, last_init_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               wr_valid_q, wr_valid_d;
  logic [1:0]         wr_rb_q, wr_rb_d;
  logic [7:0]         wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic               init_ack_q, init_ack_d;
  logic               host_ovf_q, host_ovf_d;
  logic               busy_q, busy_d;
  logic [15:0]        wr_count_q, wr_count_d;

  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               push_c, pop_c, push_ok_c, drop_c, full_c, host_pend_c;
  logic [1:0]         push_rb_c;
  logic [ENT_W-1:0]   push_ent_c;

  // Host capture: lowest-numbered bank wins when several strobes coincide
  always_comb begin
    push_c     = rb1_wen | rb2_wen | rb3_wen | rb4_wen;
    push_rb_c  = rb1_wen ? 2'd0 : rb2_wen ? 2'd1 : rb3_wen ? 2'd2 : 2'd3;
    push_ent_c = {push_rb_c, reg_addr, reg_data};
  end

  // Next-state: arbitration, issue/gap sequencing, FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    last_init_d = last_init_q;
    gap_d       = gap_q;
    wr_valid_d  = wr_valid_q;
    wr_rb_d     = wr_rb_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    init_ack_d  = 1'b0;
    wr_count_d  = wr_count_q;
    pop_c       = 1'b0;
    host_pend_c = (cnt_q != '0);

    case (state_q)
      S_IDLE: begin
        if (host_pend_c && (!init_req || last_init_q)) begin
          {wr_rb_d, wr_addr_d, wr_data_d} = mem_q[rd_ptr_q];
          pop_c       = 1'b1;
          last_init_d = 1'b0;
          wr_valid_d  = 1'b1;
          state_d     = S_ISSUE;
        end else if (init_req) begin
          wr_rb_d     = init_rb;
          wr_addr_d   = init_addr;
          wr_data_d   = init_data;
          init_ack_d  = 1'b1;
          last_init_d = 1'b1;
          wr_valid_d  = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          wr_count_d = wr_count_q + 16'd1;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP_CYCLES);
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    full_c    = (cnt_q == CNT_W'(DEPTH));
    push_ok_c = push_c && (!full_c || pop_c);
    drop_c    = push_c && full_c && !pop_c;
    if (pop_c)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (push_ok_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    cnt_d = cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);

    // Overflow is sticky; a drop beats a simultaneous clear
    host_ovf_d = drop_c ? 1'b1 : (ovf_clr ? 1'b0 : host_ovf_q);
    busy_d     = (state_d != S_IDLE) || (cnt_d != '0);
  end

  // Control and output registers
  always_ff @(posedge clk_fix) begin
    if (rst_fix) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      last_init_q <= 1'b1;
      gap_q       <= '0;
      wr_valid_q  <= 1'b0;
      wr_rb_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      init_ack_q  <= 1'b0;
      host_ovf_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      last_init_q <= last_init_d;
      gap_q       <= gap_d;
      wr_valid_q  <= wr_valid_d;
      wr_rb_q     <= wr_rb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      init_ack_q  <= init_ack_d;
      host_ovf_q  <= host_ovf_d;
      busy_q      <= busy_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy count is zero
  always_ff @(posedge clk_fix) begin
    if (push_ok_c && !rst_fix) mem_q[wr_ptr_q] <= push_ent_c;
  end

  assign init_ack = init_ack_q;
  assign wr_valid = wr_valid_q;
  assign wr_rb    = wr_rb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign host_ovf = host_ovf_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_cl_cfg_write_sched.sv
// Directed bench for cl_cfg_write_sched (FIFO_AW=2, GAP_CYCLES=8).
module tb_cl_cfg_write_sched;

  logic        clk_fix = 1'b0;
  logic        rst_fix;
  logic        rb1_wen, rb2_wen, rb3_wen, rb4_wen;
  logic [7:0]  reg_addr, reg_data;
  logic        init_req;
  logic [1:0]  init_rb;
  logic [7:0]  init_addr, init_data;
  logic        init_ack;
  logic        wr_valid;
  logic [1:0]  wr_rb;
  logic [7:0]  wr_addr, wr_data;
  logic        wr_ready;
  logic        ovf_clr;
  logic        host_ovf;
  logic        busy;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  cl_cfg_write_sched #(.FIFO_AW(2), .GAP_CYCLES(8)) dut (
    .clk_fix(clk_fix), .rst_fix(rst_fix),
    .rb1_wen(rb1_wen), .rb2_wen(rb2_wen), .rb3_wen(rb3_wen), .rb4_wen(rb4_wen),
    .reg_addr(reg_addr), .reg_data(reg_data),
    .init_req(init_req), .init_rb(init_rb), .init_addr(init_addr), .init_data(init_data),
    .init_ack(init_ack),
    .wr_valid(wr_valid), .wr_rb(wr_rb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .ovf_clr(ovf_clr), .host_ovf(host_ovf),
    .busy(busy), .wr_count(wr_count)
  );

  always #5 clk_fix = ~clk_fix;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_fix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_pulse(input int bank, input logic [7:0] a, input logic [7:0] d);
    rb1_wen = (bank == 0); rb2_wen = (bank == 1);
    rb3_wen = (bank == 2); rb4_wen = (bank == 3);
    reg_addr = a; reg_data = d;
    tick();
    rb1_wen = 1'b0; rb2_wen = 1'b0; rb3_wen = 1'b0; rb4_wen = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (!wr_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(wr_valid), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_fix = 1'b1;
    tick();
    tick();
    rst_fix = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    rst_fix = 1'b1;
    rb1_wen = 1'b0; rb2_wen = 1'b0; rb3_wen = 1'b0; rb4_wen = 1'b0;
    reg_addr = '0; reg_data = '0;
    init_req = 1'b0; init_rb = '0; init_addr = '0; init_data = '0;
    wr_ready = 1'b1; ovf_clr = 1'b0;

    // Reset values
    do_reset();
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_rb",    32'(wr_rb),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    chk("rst_init_ack", 32'(init_ack), 32'd0);
    chk("rst_host_ovf", 32'(host_ovf), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);

    // Single rb3 write: push at E0, grant at E1, transfer at E2
    host_pulse(2, 8'h12, 8'hA5);
    chk("t1_no_valid_yet", 32'(wr_valid), 32'd0);
    chk("t1_busy_queued",  32'(busy),     32'd1);
    tick();
    chk("t1_valid", 32'(wr_valid), 32'd1);
    chk("t1_rb",    32'(wr_rb),    32'd2);
    chk("t1_addr",  32'(wr_addr),  32'h12);
    chk("t1_data",  32'(wr_data),  32'hA5);
    tick();
    chk("t1_valid_drop", 32'(wr_valid), 32'd0);
    chk("t1_count",      32'(wr_count), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("t1_busy_in_gap", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_done", 32'(busy), 32'd0);

    // rb1 and rb4 together: one write on bank 0
    rb1_wen = 1'b1; rb4_wen = 1'b1; reg_addr = 8'h01; reg_data = 8'h3C;
    tick();
    rb1_wen = 1'b0; rb4_wen = 1'b0;
    tick();
    chk("t2_valid", 32'(wr_valid), 32'd1);
    chk("t2_rb",    32'(wr_rb),    32'd0);
    chk("t2_addr",  32'(wr_addr),  32'h01);
    seen = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      if (wr_valid) seen = 1'b1;
      tick();
    end
    chk("t2_single_write", 32'(seen),     32'd0);
    chk("t2_count",        32'(wr_count), 32'd2);
    chk("t2_idle",         32'(busy),     32'd0);

    // Overflow: entry 0 is granted at once, 1..4 fill the FIFO, 5 is dropped
    wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      host_pulse(1, 8'h20 + 8'(i), 8'(i));
      if (i == 4) chk("t3_no_ovf_yet", 32'(host_ovf), 32'd0);
    end
    chk("t3_ovf",       32'(host_ovf), 32'd1);
    chk("t3_held_data", 32'(wr_data),  32'd0);
    wr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(20, n);
      chk("t3_order", 32'(wr_data), 32'(k));
      tick();
    end
    wait_idle(30);
    chk("t3_count",     32'(wr_count), 32'd7);
    chk("t3_ovf_still", 32'(host_ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(host_ovf), 32'd0);

    // Round-robin: host, init, host
    do_reset();
    host_pulse(0, 8'h10, 8'hA0);
    init_req = 1'b1; init_rb = 2'd3; init_addr = 8'h40; init_data = 8'h77;
    host_pulse(1, 8'h11, 8'hA1);
    chk("t4_first_host", 32'(wr_data),  32'hA0);
    chk("t4_no_ack_1",   32'(init_ack), 32'd0);
    tick();
    wait_valid(20, n);
    chk("t4_init_data", 32'(wr_data),  32'h77);
    chk("t4_init_addr", 32'(wr_addr),  32'h40);
    chk("t4_init_rb",   32'(wr_rb),    32'd3);
    chk("t4_ack",       32'(init_ack), 32'd1);
    init_req = 1'b0;
    tick();
    chk("t4_ack_pulse", 32'(init_ack), 32'd0);
    wait_valid(20, n);
    chk("t4_last_host", 32'(wr_data),  32'hA1);
    chk("t4_no_ack_3",  32'(init_ack), 32'd0);
    tick();
    wait_idle(30);
    chk("t4_count", 32'(wr_count), 32'd3);

    // Stall for 10 cycles, then measure transfer-to-next-grant spacing
    wr_ready = 1'b0;
    host_pulse(3, 8'h33, 8'h5A);
    tick();
    chk("t5_valid", 32'(wr_valid), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) host_pulse(3, 8'h34, 8'h5B);
      else tick();
      if (!(wr_valid && wr_rb == 2'd3 && wr_addr == 8'h33 && wr_data == 8'h5A)) seen = 1'b1;
    end
    chk("t5_stable", 32'(seen), 32'd0);
    wr_ready = 1'b1;
    tick();
    chk("t5_xfer", 32'(wr_valid), 32'd0);
    wait_valid(30, n);
    chk("t5_spacing", 32'(n),       32'd9);
    chk("t5_second",  32'(wr_data), 32'h5B);
    tick();
    wait_idle(30);

    // Reset mid-write with three entries queued
    do_reset();
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) host_pulse(0, 8'h50 + 8'(i), 8'hC0 + 8'(i));
    chk("t6_valid_pre", 32'(wr_valid), 32'd1);
    rst_fix = 1'b1;
    tick();
    rst_fix = 1'b0;
    chk("t6_valid_rst", 32'(wr_valid), 32'd0);
    chk("t6_busy_rst",  32'(busy),     32'd0);
    chk("t6_count_rst", 32'(wr_count), 32'd0);
    wr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_valid || busy) seen = 1'b1;
    end
    chk("t6_no_writes", 32'(seen),     32'd0);
    chk("t6_count_end", 32'(wr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
